// File: rtl/jpeg_ctrl_pkg.sv
// Shared types and constants for the JPEG encoder block-level control path.
package jpeg_ctrl_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned NUM_ROWS = 8;
    localparam int unsigned ROW_W    = 8;
    localparam int unsigned CNT_W    = 16;

    typedef enum logic [STATE_W-1:0] {
        IDLE,
        LOAD,
        DCT,
        CAPT,
        ROWS,
        ZZ,
        HSTART,
        HWAIT,
        DONE
    } seq_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned ab;
        ab = (a > b) ? a : b;
        return (ab > c) ? ab : c;
    endfunction

endpackage

// File: rtl/jpeg_seq_timer.sv
// Loadable down-counter with a registered zero flag; stops at zero.
module jpeg_seq_timer #(
    parameter int unsigned WIDTH = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    output logic [WIDTH-1:0] count_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
        zero_d = (cnt_d == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
        end
    end

    assign count_o = cnt_q;
    assign zero_o  = zero_q;

endmodule

// File: rtl/jpeg_block_sequencer.sv
// Per-8x8-block control sequencer: accepts one block per handshake and steps
// load, DCT, capture, row quantize, zigzag and Huffman, then waits for done.
module jpeg_block_sequencer
    import jpeg_ctrl_pkg::*;
#(
    parameter int unsigned DCT_CYCLES    = 8,
    parameter int unsigned QUANT_LATENCY = 1,
    parameter int unsigned HUFF_TIMEOUT  = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             block_valid,
    output logic             block_ready,
    input  logic             huffman_done,
    input  logic             abort,
    output logic             input_enable,
    output logic             dct_enable,
    output logic             dct_end_enable,
    output logic [ROW_W-1:0] matrix_row,
    output logic             zigzag_input_enable,
    output logic             zigag_enable,
    output logic             Huffman_start,
    output logic             busy,
    output logic             block_done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] block_count
);

    localparam int unsigned TMR_W =
        $clog2(max3(DCT_CYCLES, QUANT_LATENCY + 1, HUFF_TIMEOUT) + 1);

    seq_state_e       state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             timeout_q, timeout_d;
    logic             input_en_q, input_en_d;
    logic             dct_en_q, dct_en_d;
    logic             capt_q, capt_d;
    logic             zz_in_q, zz_in_d;
    logic             zig_q, zig_d;
    logic             hstart_q, hstart_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_value;
    logic [TMR_W-1:0] tmr_count;
    logic             tmr_zero;

    // One timer is time-shared: DCT run length, per-row hold, Huffman watchdog.
    jpeg_seq_timer #(.WIDTH(TMR_W)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .count_o (tmr_count),
        .zero_o  (tmr_zero)
    );

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        count_d   = count_q;
        timeout_d = timeout_q;
        tmr_load  = 1'b0;
        tmr_value = '0;

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (block_valid) begin
                        state_d   = LOAD;
                        timeout_d = 1'b0;
                    end
                end
                LOAD: begin
                    state_d   = DCT;
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(DCT_CYCLES - 1);
                end
                DCT: begin
                    if (tmr_zero) state_d = CAPT;
                end
                CAPT: begin
                    state_d   = ROWS;
                    row_d     = '0;
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(QUANT_LATENCY);
                end
                ROWS: begin
                    if (tmr_zero) begin
                        if (row_q == ROW_W'(NUM_ROWS - 1)) begin
                            state_d = ZZ;
                        end else begin
                            row_d     = row_q + ROW_W'(1);
                            tmr_load  = 1'b1;
                            tmr_value = TMR_W'(QUANT_LATENCY);
                        end
                    end
                end
                ZZ: state_d = HSTART;
                HSTART: begin
                    // The HSTART cycle counts toward the watchdog window.
                    state_d   = HWAIT;
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(HUFF_TIMEOUT - 2);
                end
                HWAIT: begin
                    if (huffman_done) begin
                        state_d = DONE;
                        count_d = count_q + CNT_W'(1);
                    end else if (tmr_zero) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Strobes are decoded from the next state so they line up with it.
        input_en_d = (state_d == LOAD);
        dct_en_d   = (state_d == DCT);
        capt_d     = (state_d == CAPT);
        zz_in_d    = (state_d == ROWS) &&
                     (tmr_load ? (QUANT_LATENCY == 0) : (tmr_count == TMR_W'(1)));
        zig_d      = (state_d == ZZ);
        hstart_d   = (state_d == HSTART);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            count_q    <= '0;
            timeout_q  <= 1'b0;
            input_en_q <= 1'b0;
            dct_en_q   <= 1'b0;
            capt_q     <= 1'b0;
            zz_in_q    <= 1'b0;
            zig_q      <= 1'b0;
            hstart_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            count_q    <= count_d;
            timeout_q  <= timeout_d;
            input_en_q <= input_en_d;
            dct_en_q   <= dct_en_d;
            capt_q     <= capt_d;
            zz_in_q    <= zz_in_d;
            zig_q      <= zig_d;
            hstart_q   <= hstart_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign block_ready         = (state_q == IDLE) && !reset;
    assign input_enable        = input_en_q;
    assign dct_enable          = dct_en_q;
    assign dct_end_enable      = capt_q;
    assign matrix_row          = row_q;
    assign zigzag_input_enable = zz_in_q;
    assign zigag_enable        = zig_q;
    assign Huffman_start       = hstart_q;
    assign busy                = busy_q;
    assign block_done          = done_q;
    assign timeout_err         = timeout_q;
    assign block_count         = count_q;

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// Bench for jpeg_block_sequencer: three parameterisations on shared stimulus,
// each compared every cycle to a cycles-since-accept reference model.
module tb_jpeg_block_sequencer;

    localparam int P_D [3] = '{8, 8, 1};
    localparam int P_Q [3] = '{1, 1, 0};
    localparam int P_T [3] = '{1024, 16, 8};

    logic        clock, reset, vld, hdone, abrt;
    logic [2:0]  ready, busy, ien, dct, capt, zzin, zig, hst, bdone, terr;
    logic [7:0]  mrow [3];
    logic [15:0] bcnt [3];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        int k;
        bit dn;
        int cnt;
        bit terr;
        int row;
    } mdl_t;
    mdl_t m [3];

    jpeg_block_sequencer #(.DCT_CYCLES(8), .QUANT_LATENCY(1), .HUFF_TIMEOUT(1024)) u_def (
        .clock(clock), .reset(reset), .block_valid(vld), .block_ready(ready[0]),
        .huffman_done(hdone), .abort(abrt), .input_enable(ien[0]), .dct_enable(dct[0]),
        .dct_end_enable(capt[0]), .matrix_row(mrow[0]), .zigzag_input_enable(zzin[0]),
        .zigag_enable(zig[0]), .Huffman_start(hst[0]), .busy(busy[0]),
        .block_done(bdone[0]), .timeout_err(terr[0]), .block_count(bcnt[0]));

    jpeg_block_sequencer #(.DCT_CYCLES(8), .QUANT_LATENCY(1), .HUFF_TIMEOUT(16)) u_to (
        .clock(clock), .reset(reset), .block_valid(vld), .block_ready(ready[1]),
        .huffman_done(hdone), .abort(abrt), .input_enable(ien[1]), .dct_enable(dct[1]),
        .dct_end_enable(capt[1]), .matrix_row(mrow[1]), .zigzag_input_enable(zzin[1]),
        .zigag_enable(zig[1]), .Huffman_start(hst[1]), .busy(busy[1]),
        .block_done(bdone[1]), .timeout_err(terr[1]), .block_count(bcnt[1]));

    jpeg_block_sequencer #(.DCT_CYCLES(1), .QUANT_LATENCY(0), .HUFF_TIMEOUT(8)) u_fast (
        .clock(clock), .reset(reset), .block_valid(vld), .block_ready(ready[2]),
        .huffman_done(hdone), .abort(abrt), .input_enable(ien[2]), .dct_enable(dct[2]),
        .dct_end_enable(capt[2]), .matrix_row(mrow[2]), .zigzag_input_enable(zzin[2]),
        .zigag_enable(zig[2]), .Huffman_start(hst[2]), .busy(busy[2]),
        .block_done(bdone[2]), .timeout_err(terr[2]), .block_count(bcnt[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Model state k = cycles since accept (0 = idle); dn marks the completion cycle.
    task automatic mdl_step(input int i);
        int r0, ph;
        r0 = P_D[i] + 3;
        ph = r0 + 8 * (P_Q[i] + 1) + 1;
        if (reset) begin
            m[i] = '{default: 0};
        end else if (m[i].k == 0 && !m[i].dn) begin
            if (vld) begin
                m[i].k    = 1;
                m[i].terr = 1'b0;
            end
        end else if (m[i].dn || abrt) begin
            m[i].k  = 0;
            m[i].dn = 1'b0;
        end else if (m[i].k > ph && hdone) begin
            m[i].k   = 0;
            m[i].dn  = 1'b1;
            m[i].cnt = (m[i].cnt + 1) % 65536;
        end else if (m[i].k > ph && m[i].k - ph >= P_T[i] - 1) begin
            m[i].k    = 0;
            m[i].terr = 1'b1;
        end else begin
            m[i].k = m[i].k + 1;
        end
        if (m[i].k >= r0 && m[i].k < ph - 1) m[i].row = (m[i].k - r0) / (P_Q[i] + 1);
    endtask

    function automatic logic [9:0] exp_flags(input int i);
        int   k, d, q, r0, ph;
        logic bz;
        k  = m[i].k;
        d  = P_D[i];
        q  = P_Q[i];
        r0 = d + 3;
        ph = r0 + 8 * (q + 1) + 1;
        bz = (k != 0) || m[i].dn;
        exp_flags = {!bz && !reset, bz, k == 1, (k >= 2) && (k <= d + 1), k == d + 2,
                     (k >= r0) && (k < ph - 1) && ((k - r0) % (q + 1) == q),
                     k == ph - 1, k == ph, m[i].dn == 1'b1, m[i].terr == 1'b1};
    endfunction

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("flags[%0d] rdy,busy,in,dct,capt,zzin,zig,hst,done,terr", i),
                  32'({ready[i], busy[i], ien[i], dct[i], capt[i], zzin[i], zig[i],
                       hst[i], bdone[i], terr[i]}), 32'(exp_flags(i)));
            check($sformatf("matrix_row[%0d]", i), 32'(mrow[i]), 32'(m[i].row));
            check($sformatf("block_count[%0d]", i), 32'(bcnt[i]), 32'(m[i].cnt));
            check($sformatf("strobe_onehot[%0d]", i),
                  32'($onehot0({ien[i], capt[i], zzin[i], zig[i], hst[i]})), 32'd1);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        for (int i = 0; i < 3; i++) mdl_step(i);
        #1;
        cyc++;
        check_all();
    endtask

    function automatic logic cond(input int what, input int i);
        case (what)
            0:       cond = hst[i];
            1:       cond = (mrow[i] == 8'd4);
            2:       cond = dct[i];
            3:       cond = (busy == 3'b000);
            default: cond = capt[i];
        endcase
    endfunction

    task automatic wait_for(input string tag, input int what, input int i, input int limit);
        int n;
        n = 0;
        while (!cond(what, i) && n < limit) begin
            tick();
            n++;
        end
        check(tag, 32'(cond(what, i)), 32'd1);
    endtask

    initial begin
        int t_hs0, t_hs2, t_bd0, base;
        for (int i = 0; i < 3; i++) m[i] = '{default: 0};
        reset = 1'b1;
        vld   = 1'b0;
        hdone = 1'b0;
        abrt  = 1'b0;
        tick();
        tick();
        check("reset_ready", 32'(ready), 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(ready), 32'h7);

        // Single block at defaults, huffman_done 35 cycles after accept.
        vld = 1'b1;
        tick();
        vld = 1'b0;
        t_hs0 = -1;
        t_hs2 = -1;
        t_bd0 = -1;
        for (int k = 1; k <= 40; k++) begin
            if (hst[0])   t_hs0 = k;
            if (hst[2])   t_hs2 = k;
            if (bdone[0]) t_bd0 = k;
            hdone = (k == 35);
            tick();
        end
        hdone = 1'b0;
        check("latency_hstart_def", 32'(t_hs0), 32'd28);
        check("latency_hstart_fast", 32'(t_hs2), 32'd13);
        check("latency_block_done", 32'(t_bd0), 32'd36);
        check("count_after_one", 32'(bcnt[0]), 32'd1);

        // Back-to-back blocks with block_valid held high.
        base = int'(bcnt[0]);
        vld  = 1'b1;
        for (int b = 0; b < 3; b++) begin
            wait_for("b2b_wait_hstart", 0, 0, 100);
            repeat (5) tick();
            hdone = 1'b1;
            tick();
            hdone = 1'b0;
        end
        vld = 1'b0;
        tick();
        tick();
        check("b2b_count", 32'(bcnt[0]), 32'(base + 3));

        // Huffman watchdog on the 16-cycle instance.
        wait_for("to_wait_idle", 3, 0, 2000);
        vld = 1'b1;
        tick();
        vld = 1'b0;
        wait_for("to_wait_hstart", 0, 1, 60);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 15) check("to_not_yet", 32'(terr[1]), 32'd0);
        end
        check("to_set", 32'(terr[1]), 32'd1);
        check("to_idle", 32'(busy[1]), 32'd0);
        vld = 1'b1;
        tick();
        vld = 1'b0;
        check("to_cleared", 32'(terr[1]), 32'd0);
        abrt = 1'b1;
        tick();
        abrt = 1'b0;
        check("abort_all_idle", 32'(busy), 32'd0);

        // Abort at row 4, then a clean block restarting from row 0.
        base = int'(bcnt[0]);
        vld  = 1'b1;
        tick();
        vld = 1'b0;
        wait_for("ab_wait_row4", 1, 0, 60);
        abrt = 1'b1;
        tick();
        abrt = 1'b0;
        check("ab_busy", 32'(busy[0]), 32'd0);
        check("ab_strobes", 32'({ien[0], dct[0], capt[0], zzin[0], zig[0], hst[0], bdone[0]}), 32'd0);
        check("ab_count", 32'(bcnt[0]), 32'(base));
        vld = 1'b1;
        tick();
        vld = 1'b0;
        wait_for("ab_wait_capt", 4, 0, 40);
        tick();
        check("ab_row0", 32'(mrow[0]), 32'd0);
        wait_for("ab_wait_hstart", 0, 0, 60);
        tick();
        hdone = 1'b1;
        tick();
        hdone = 1'b0;
        tick();
        check("ab_count_next", 32'(bcnt[0]), 32'(base + 1));

        // Asynchronous reset in the middle of the DCT phase.
        vld = 1'b1;
        tick();
        vld = 1'b0;
        wait_for("rs_wait_dct", 2, 0, 20);
        tick();
        tick();
        #2;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) m[i] = '{default: 0};
        #1;
        check("rs_dct_drop", 32'(dct[0]), 32'd0);
        check("rs_ready_low", 32'(ready[0]), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rs_ready_high", 32'(ready[0]), 32'd1);
        check("rs_count_zero", 32'(bcnt[0]), 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            vld   = ($urandom_range(0, 3) == 0);
            hdone = ($urandom_range(0, 7) == 0);
            abrt  = ($urandom_range(0, 63) == 0);
            tick();
        end
        vld   = 1'b0;
        hdone = 1'b0;
        abrt  = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
